// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU command sequencer: FSM states, the queued command
// record and the default operand/op/tag widths used by the ALU.
package alu_seq_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int A_OP_W_DEF = 3;
  localparam int B_OP_W_DEF = 2;
  localparam int TAG_W_DEF  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic [DATA_W_DEF-1:0] a;
    logic [DATA_W_DEF-1:0] b;
    logic [A_OP_W_DEF-1:0] a_op;
    logic [B_OP_W_DEF-1:0] b_op;
    logic                  a_en;
    logic                  b_en;
    logic [TAG_W_DEF-1:0]  tag;
  } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO of alu_cmd_t records with full/empty flags.
// Pointers wrap naturally because DEPTH is a power of two.
module alu_cmd_fifo
  import alu_seq_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     push,
  input  alu_cmd_t wdata,
  input  logic     pop,
  output alu_cmd_t rdata,
  output logic     full,
  output logic     empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  alu_cmd_t        mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q,  count_d;
  logic            do_push, do_pop;

  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues one at a time as a single-cycle ALU_en pulse,
// waits ALU_LAT cycles, captures C and returns it with the command tag.
module alu_cmd_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int A_OP_W  = A_OP_W_DEF,
  parameter int B_OP_W  = B_OP_W_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int DEPTH   = 4,
  parameter int ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [A_OP_W-1:0] cmd_a_op,
  input  logic [B_OP_W-1:0] cmd_b_op,
  input  logic              cmd_a_en,
  input  logic              cmd_b_en,
  input  logic [TAG_W-1:0]  cmd_tag,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [A_OP_W-1:0] a_op,
  output logic [B_OP_W-1:0] b_op,
  output logic              a_en,
  output logic              b_en,
  output logic              ALU_en,
  input  logic [DATA_W-1:0] C,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [TAG_W-1:0]  res_tag,
  output logic              busy
);

  localparam int LAT_W = $clog2(ALU_LAT + 1);
  localparam logic [LAT_W-1:0] LAT_C = LAT_W'(ALU_LAT);
  localparam logic [LAT_W-1:0] ONE_C = LAT_W'(1);

  alu_cmd_t cmd_in, head;
  logic     fifo_full, fifo_empty, fifo_push, fifo_pop;

  seq_state_e        state_q,     state_d;
  logic [DATA_W-1:0] a_q,         a_d;
  logic [DATA_W-1:0] b_q,         b_d;
  logic [A_OP_W-1:0] a_op_q,      a_op_d;
  logic [B_OP_W-1:0] b_op_q,      b_op_d;
  logic              a_en_q,      a_en_d;
  logic              b_en_q,      b_en_d;
  logic              alu_en_q,    alu_en_d;
  logic [TAG_W-1:0]  tag_q,       tag_d;
  logic [LAT_W-1:0]  cnt_q,       cnt_d;
  logic              res_valid_q, res_valid_d;
  logic [DATA_W-1:0] res_data_q,  res_data_d;
  logic [TAG_W-1:0]  res_tag_q,   res_tag_d;

  always_comb begin
    cmd_in.a    = cmd_a;
    cmd_in.b    = cmd_b;
    cmd_in.a_op = cmd_a_op;
    cmd_in.b_op = cmd_b_op;
    cmd_in.a_en = cmd_a_en;
    cmd_in.b_en = cmd_b_en;
    cmd_in.tag  = cmd_tag;
  end

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;

  alu_cmd_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .wdata (cmd_in),
    .pop   (fifo_pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    a_op_d      = a_op_q;
    b_op_d      = b_op_q;
    a_en_d      = a_en_q;
    b_en_d      = b_en_q;
    alu_en_d    = 1'b0;
    tag_d       = tag_q;
    cnt_d       = cnt_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_tag_d   = res_tag_q;
    fifo_pop    = 1'b0;

    case (state_q)
      IDLE: begin
        // The issue registers are the ALU outputs, so loading them here
        // presents the command during the ISSUE cycle.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          a_d      = head.a;
          b_d      = head.b;
          a_op_d   = head.a_op;
          b_op_d   = head.b_op;
          a_en_d   = head.a_en;
          b_en_d   = head.b_en;
          tag_d    = head.tag;
          alu_en_d = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        a_en_d  = 1'b0;
        b_en_d  = 1'b0;
        cnt_d   = LAT_C;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == ONE_C) begin
          res_data_d  = C;
          res_tag_d   = tag_q;
          res_valid_d = 1'b1;
          state_d     = HOLD;
        end else begin
          cnt_d = cnt_q - ONE_C;
        end
      end
      HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      a_op_q      <= '0;
      b_op_q      <= '0;
      a_en_q      <= 1'b0;
      b_en_q      <= 1'b0;
      alu_en_q    <= 1'b0;
      tag_q       <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_tag_q   <= '0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      a_op_q      <= a_op_d;
      b_op_q      <= b_op_d;
      a_en_q      <= a_en_d;
      b_en_q      <= b_en_d;
      alu_en_q    <= alu_en_d;
      tag_q       <= tag_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_tag_q   <= res_tag_d;
    end
  end

  assign A         = a_q;
  assign B         = b_q;
  assign a_op      = a_op_q;
  assign b_op      = b_op_q;
  assign a_en      = a_en_q;
  assign b_en      = b_en_q;
  assign ALU_en    = alu_en_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_tag   = res_tag_q;
  assign busy      = (state_q != IDLE) || !fifo_empty;

endmodule

// File: doc/alu_cmd_sequencer.md
Name: alu_cmd_sequencer

Overview:
Upstream feeder for the ALU. It accepts operation commands over a valid/ready handshake and queues them in a small FIFO. It issues each command to the ALU as a single-cycle ALU_en pulse, then waits the ALU's pipeline latency and captures C. The captured result is returned with the command's tag on a valid/ready result port. One command is in flight at a time, and results come back strictly in order.

Parameters:
DATA_W, 8, width of A, B and C
A_OP_W, 3, width of a_op
B_OP_W, 2, width of b_op
TAG_W, 4, width of the command/result tag
DEPTH, 4, command FIFO entries (power of 2, at least 2)
ALU_LAT, 1, cycles from the ALU_en sampling edge until C is valid (at least 1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted when high together with cmd_valid
cmd_a, cmd_b  in  DATA_W  operands
cmd_a_op  in  A_OP_W  operation select for the A group
cmd_b_op  in  B_OP_W  operation select for the B group
cmd_a_en, cmd_b_en  in  1  operation-group enables
cmd_tag  in  TAG_W  opaque ID, returned with the result
A, B  out  DATA_W  to ALU operands
a_op  out  A_OP_W  to ALU
b_op  out  B_OP_W  to ALU
a_en, b_en, ALU_en  out  1  to ALU
C  in  DATA_W  from ALU result
res_valid  out  1  result available
res_ready  in  1  result consumed when high together with res_valid
res_data  out  DATA_W  captured C
res_tag  out  TAG_W  tag of the command that produced res_data
busy  out  1  high when state != IDLE or the FIFO is not empty

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values:
  - FIFO empty, state IDLE.
  - A, B, a_op, b_op, a_en, b_en, ALU_en, res_valid, res_data, res_tag all 0.
  - cmd_ready = 1 after reset; busy = 0.
- FIFO:
  - cmd_ready = !full (no bypass of a full FIFO).
  - Push when cmd_valid && cmd_ready.
  - Simultaneous push and pop is legal whenever the FIFO is not full; occupancy is unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - Pushing with cmd_valid=1 while full is impossible by construction, and cmd fields are ignored.
- All ALU-side outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE:
    - If the FIFO is not empty: pop the head into the issue register and go to ISSUE.
    - Otherwise stay in IDLE.
  - ISSUE (exactly 1 cycle):
    - A, B, a_op, b_op, a_en, b_en are driven from the popped command, with ALU_en = 1.
    - Load the latency counter with ALU_LAT, then go to WAIT.
  - WAIT (ALU_LAT cycles):
    - ALU_en, a_en, b_en = 0; A, B, a_op, b_op hold their last values.
    - On the last WAIT cycle, sample C into res_data and the held tag into res_tag, then go to HOLD.
  - HOLD:
    - res_valid = 1, with res_data and res_tag stable.
    - When res_ready = 1: res_valid drops next cycle and the FSM returns to IDLE.
- Timing:
  - With the ISSUE cycle at t, res_valid is first high at t + ALU_LAT + 1.
  - With res_ready held at 1, ALU_en pulses are spaced ALU_LAT + 3 cycles apart.
- ALU_en is never high for two consecutive cycles.
- Enables: a_en and b_en are only ever high in the ISSUE cycle.
- No arithmetic is performed here; C is captured verbatim, at full DATA_W, with no extension.
- Reset mid-operation clears everything immediately:
  - The in-flight result is discarded and res_valid does not assert.
  - Queued commands are dropped.
- cmd_ready stays independent of res_ready except through FIFO fullness.

Decomposition:
- Package alu_seq_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, HOLD);
  - a packed struct alu_cmd_t {a, b, a_op, b_op, a_en, b_en, tag};
  - default width localparams shared with the ALU.
- Sub-module alu_cmd_fifo: synchronous FIFO of alu_cmd_t, DEPTH entries, with full/empty flags.
- The FSM and the result register live in alu_cmd_sequencer.

Test Plan:
1. Reset: assert rst_n=0 mid-cycle, asynchronously → all outputs 0, cmd_ready=1, busy=0 without waiting for a clk edge.
2. Single command, ALU_LAT=1, bench ALU returns C=8'd8:
   - Stimulus: cmd_a=5, cmd_b=3, a_op=0, a_en=1, tag=4'h7.
   - Required: exactly one ALU_en cycle with A=5, B=3, a_en=1.
   - Required: res_valid at issue+2 with res_data=8, res_tag=7.
3. Fill with res_ready=0: offer 6 back-to-back commands → exactly 5 accepted (1 in flight, 4 queued), cmd_ready low afterwards, exactly one ALU_en pulse.
4. Backpressure: hold res_ready=0 for 10 cycles in HOLD → res_data and res_tag stable, res_valid stays 1, no ALU_en. Then raise res_ready → next ALU_en 2 cycles later.
5. Ordering: tags 1, 2, 3 with res_ready=1 → results return in tag order 1, 2, 3 with ALU_en pulses exactly 4 cycles apart.
6. Reset during WAIT with 2 commands queued → res_valid never asserts. After release: busy=0, cmd_ready=1, FIFO empty.
